operand_fetch: RTL and testbench

Issue stage that sits between decode and execute, and is the sole read-side client of the architectural register file.
- Reads rs1/rs2 from the regfile.
- Tracks in-flight writers per register with a counting scoreboard.
- Bypasses same-cycle writeback data.
- Stalls decode on RAW hazards.
- Holds one registered issue slot toward execute under a valid/ready handshake.

---
 rtl/operand_fetch_pkg.sv | 19 +
 rtl/operand_fetch_scoreboard.sv | 59 +++++
 rtl/operand_fetch.sv | 134 +++++++++++++
 tb/tb_operand_fetch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand fetch stage: register address, 64-bit data,
// and the issue bundle held in the slot toward execute.
package operand_fetch_pkg;

    localparam int CTL_W_DEFAULT = 32;

    typedef logic [4:0]  creg_addr_t;
    typedef logic [63:0] u64;

    typedef struct packed {
        u64                       pc;
        u64                       src1;
        u64                       src2;
        creg_addr_t               rd;
        logic                     rd_we;
        logic [CTL_W_DEFAULT-1:0] ctl;
    } issue_bundle_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Counting scoreboard: one saturating in-flight-writer counter per register.
// Register 0 is never counted; a same-cycle inc and dec of one register cancel.
module operand_fetch_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inc,
    input  creg_addr_t                  inc_addr,
    input  logic                        dec,
    input  creg_addr_t                  dec_addr,
    output logic [NREG-1:0][CNT_W-1:0]  count,
    output logic [NREG-1:0]             busy
);

    logic [NREG-1:0][CNT_W-1:0] cnt_q;
    logic [NREG-1:0]            up;
    logic [NREG-1:0]            dn;

    always_comb begin
        up = '0;
        dn = '0;
        for (int r = 0; r < NREG; r++) begin
            up[r] = inc && (inc_addr == creg_addr_t'(r));
            dn[r] = dec && (dec_addr == creg_addr_t'(r));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (up[r] && !dn[r] && cnt_q[r] != '1)
                    cnt_q[r] <= cnt_q[r] + 1'b1;
                else if (dn[r] && !up[r] && cnt_q[r] != '0)
                    cnt_q[r] <= cnt_q[r] - 1'b1;
            end
        end
    end

    // A release against an idle counter means downstream lost track of a writer.
    always_ff @(posedge clk) begin
        if (reset)
            assert (!(dec && !(inc && inc_addr == dec_addr) && cnt_q[dec_addr] == '0));
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < NREG; r++)
            busy[r] = (cnt_q[r] != '0);
    end

    assign count = cnt_q;

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: regfile read, RAW/structural stall via scoreboard, wb bypass,
// one-entry issue slot. Define OPERAND_FETCH_EX_BYPASS_EN for the execute-stage bypass.
// Handshakes: a transfer happens on a cycle where valid && ready; once valid is
// raised the offering side keeps it and its payload stable until the transfer.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = 2,
    parameter int CTL_W = CTL_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_pc,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic             in_rd_we,
    input  logic [CTL_W-1:0] in_ctl,
    output logic [4:0]       ra1,
    output logic [4:0]       ra2,
    input  logic [63:0]      rd1,
    input  logic [63:0]      rd2,
    input  logic             wb_release,
    input  logic             wb_wen,
    input  logic [4:0]       wb_addr,
    input  logic [63:0]      wb_data,
`ifdef OPERAND_FETCH_EX_BYPASS_EN
    input  logic             ex_fwd_valid,
    input  logic [4:0]       ex_fwd_addr,
    input  logic [63:0]      ex_fwd_data,
`endif
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_pc,
    output logic [63:0]      out_src1,
    output logic [63:0]      out_src2,
    output logic [4:0]       out_rd,
    output logic             out_rd_we,
    output logic [CTL_W-1:0] out_ctl
);

    logic [NREG-1:0][CNT_W-1:0] count;
    logic [NREG-1:0]            busy;
    creg_addr_t                 src_addr [2];
    u64                         src_rf   [2];
    u64                         src_val  [2];
    logic [1:0]                 src_haz;
    logic                       struct_stall;
    logic                       accept;
    logic                       inc;
    logic                       valid_q;
    issue_bundle_t              slot_q;

    assign ra1 = in_rs1;
    assign ra2 = in_rs2;
    assign src_addr[0] = in_rs1;
    assign src_addr[1] = in_rs2;
    assign src_rf[0]   = rd1;
    assign src_rf[1]   = rd2;

    // Bypass is only legal with a single writer in flight: it must be the one retiring.
    always_comb begin
        src_haz = '0;
        for (int i = 0; i < 2; i++) begin
            src_val[i] = '0;
            if (src_addr[i] != '0) begin
                if (!busy[src_addr[i]])
                    src_val[i] = src_rf[i];
                else if (count[src_addr[i]] == CNT_W'(1) && wb_release && wb_wen
                         && wb_addr == src_addr[i])
                    src_val[i] = wb_data;
`ifdef OPERAND_FETCH_EX_BYPASS_EN
                else if (count[src_addr[i]] == CNT_W'(1) && ex_fwd_valid
                         && ex_fwd_addr == src_addr[i])
                    src_val[i] = ex_fwd_data;
`endif
                else
                    src_haz[i] = 1'b1;
            end
        end
    end

    assign struct_stall = in_rd_we && (in_rd != '0) && (count[in_rd] == '1)
                          && !(wb_release && wb_addr == in_rd);

    assign in_ready = reset && !flush && (!valid_q || out_ready)
                      && (src_haz == '0) && !struct_stall;
    assign accept   = in_valid && in_ready;
    assign inc      = accept && in_rd_we && (in_rd != '0);

    operand_fetch_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .inc      (inc),
        .inc_addr (in_rd),
        .dec      (wb_release),
        .dec_addr (wb_addr),
        .count    (count),
        .busy     (busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            slot_q  <= '0;
        end else if (accept) begin
            valid_q      <= 1'b1;
            slot_q.pc    <= in_pc;
            slot_q.src1  <= src_val[0];
            slot_q.src2  <= src_val[1];
            slot_q.rd    <= in_rd;
            slot_q.rd_we <= in_rd_we;
            slot_q.ctl   <= in_ctl;
        end else if (flush || (out_ready && valid_q)) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = slot_q.pc;
    assign out_src1  = slot_q.src1;
    assign out_src2  = slot_q.src2;
    assign out_rd    = slot_q.rd;
    assign out_rd_we = slot_q.rd_we;
    assign out_ctl   = slot_q.ctl;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed hazard/bypass/flush/reset steps followed by
// random traffic, all checked against a counter-array and regfile model.
module tb_operand_fetch;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [63:0] in_pc;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rd_we;
    logic [31:0] in_ctl;
    logic [4:0]  ra1, ra2;
    logic [63:0] rd1, rd2;
    logic        wb_release, wb_wen;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [63:0] out_pc, out_src1, out_src2;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [31:0] out_ctl;
`ifdef OPERAND_FETCH_EX_BYPASS_EN
    logic        ex_fwd_valid = 1'b0;
    logic [4:0]  ex_fwd_addr  = '0;
    logic [63:0] ex_fwd_data  = '0;
`endif

    logic [63:0] regs [32];
    int          cnt  [32];
    logic        m_valid;
    logic [63:0] m_pc, m_src1, m_src2;
    logic [4:0]  m_rd;
    logic        m_rd_we;
    logic [31:0] m_ctl;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

    operand_fetch dut (
        .clk (clk), .reset (reset),
        .in_valid (in_valid), .in_ready (in_ready), .in_pc (in_pc),
        .in_rs1 (in_rs1), .in_rs2 (in_rs2), .in_rd (in_rd), .in_rd_we (in_rd_we),
        .in_ctl (in_ctl), .ra1 (ra1), .ra2 (ra2), .rd1 (rd1), .rd2 (rd2),
        .wb_release (wb_release), .wb_wen (wb_wen), .wb_addr (wb_addr), .wb_data (wb_data),
`ifdef OPERAND_FETCH_EX_BYPASS_EN
        .ex_fwd_valid (ex_fwd_valid), .ex_fwd_addr (ex_fwd_addr), .ex_fwd_data (ex_fwd_data),
`endif
        .flush (flush), .out_valid (out_valid), .out_ready (out_ready),
        .out_pc (out_pc), .out_src1 (out_src1), .out_src2 (out_src2),
        .out_rd (out_rd), .out_rd_we (out_rd_we), .out_ctl (out_ctl)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Operand rules: {hazard, value}
    function automatic logic [64:0] resolve(logic [4:0] s);
        if (s == 5'd0) return {1'b0, 64'd0};
        if (cnt[s] == 0) return {1'b0, regs[s]};
        if (cnt[s] == 1 && wb_release && wb_wen && wb_addr == s) return {1'b0, wb_data};
        return {1'b1, 64'd0};
    endfunction

    task automatic idle();
        in_valid = 0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_rd_we = 0; in_ctl = '0; wb_release = 0; wb_wen = 0; wb_addr = '0;
        wb_data = '0; flush = 0; out_ready = 1;
    endtask

    task automatic issue(int rs1, int rs2, int rd, bit we);
        in_valid = 1; in_pc = {$urandom, $urandom}; in_ctl = $urandom;
        in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_rd = 5'(rd); in_rd_we = we;
    endtask

    task automatic wb(int addr, bit wen, logic [63:0] data);
        wb_release = 1; wb_wen = wen; wb_addr = 5'(addr); wb_data = data;
    endtask

    task automatic model_reset();
        m_valid = 0;
        for (int r = 0; r < 32; r++) cnt[r] = 0;
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        logic [64:0] r1, r2;
        logic        st, rdy, acc;
        #1;
        r1  = resolve(in_rs1);
        r2  = resolve(in_rs2);
        st  = in_rd_we && in_rd != 0 && cnt[in_rd] == MAXC && !(wb_release && wb_addr == in_rd);
        rdy = !flush && (!m_valid || out_ready) && !r1[64] && !r2[64] && !st;
        acc = in_valid && rdy;
        chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
        chk("ra1", {59'd0, ra1}, {59'd0, in_rs1});
        chk("ra2", {59'd0, ra2}, {59'd0, in_rs2});
        @(posedge clk);
        #1;
        if (acc) begin
            m_valid = 1; m_pc = in_pc; m_src1 = r1[63:0]; m_src2 = r2[63:0];
            m_rd = in_rd; m_rd_we = in_rd_we; m_ctl = in_ctl;
        end else if (flush || (out_ready && m_valid)) begin
            m_valid = 0;
        end
        if (acc && in_rd_we && in_rd != 0) cnt[in_rd]++;
        if (wb_release && cnt[wb_addr] > 0) cnt[wb_addr]--;
        if (wb_release && wb_wen && wb_addr != 0) regs[wb_addr] = wb_data;
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        if (m_valid) begin
            chk("out_pc", out_pc, m_pc);
            chk("out_src1", out_src1, m_src1);
            chk("out_src2", out_src2, m_src2);
            chk("out_rd", {59'd0, out_rd}, {59'd0, m_rd});
            chk("out_rd_we", {63'd0, out_rd_we}, {63'd0, m_rd_we});
            chk("out_ctl", {32'd0, out_ctl}, {32'd0, m_ctl});
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int pick;
        regs[0] = '0;
        for (int r = 1; r < 32; r++) regs[r] = {$urandom, $urandom};
        model_reset();
        idle();
        reset = 1;
        #2 reset = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_src1", out_src1, 64'd0);
        chk("rst_out_src2", out_src2, 64'd0);
        chk("rst_out_rd", {59'd0, out_rd}, 64'd0);
        chk("rst_out_ctl", {32'd0, out_ctl}, 64'd0);
        reset = 1;

        // RAW on x5 resolved by same-cycle writeback bypass
        issue(1, 2, 5, 1); cycle();
        issue(5, 0, 9, 0); cycle();
        chk("raw_stall", {63'd0, m_valid}, 64'd0);
        wb(5, 1, 64'hDEAD); cycle();
        chk("raw_bypass_src1", out_src1, 64'hDEAD);
        idle();

        // Two writers on x7: consumer waits for the second writeback
        issue(0, 0, 7, 1); cycle();
        issue(0, 0, 7, 1); cycle();
        issue(7, 0, 0, 0); cycle();
        wb(7, 1, 64'h1111_AAAA); cycle();
        wb(7, 1, 64'h2222_BBBB); cycle();
        chk("x7_second_wb_src1", out_src1, 64'h2222_BBBB);
        idle();

        // x0 sources and destination never touch the scoreboard
        issue(0, 0, 0, 1); wb_wen = 1; wb_addr = 0; wb_data = 64'h5555; cycle();
        chk("x0_src1", out_src1, 64'd0);
        chk("x0_src2", out_src2, 64'd0);
        idle();
        issue(0, 0, 3, 0); in_rs1 = 0; cycle();
        idle();

        // Slot held by backpressure, then flushed; squashed writer released
        issue(0, 0, 6, 1); cycle();
        out_ready = 0;
        issue(1, 2, 4, 0);
        for (int k = 0; k < 3; k++) cycle();
        flush = 1; cycle();
        idle();
        in_valid = 0; wb(6, 0, 64'hBAD0); cycle();
        idle();
        issue(6, 0, 0, 0); cycle();
        idle();

        // Saturating x3: fourth writer waits for a release
        for (int k = 0; k < 3; k++) begin issue(0, 0, 3, 1); cycle(); end
        issue(0, 0, 3, 1); cycle();
        wb(3, 0, 64'd0); cycle();
        idle();
        issue(0, 0, 3, 1); cycle();
        idle();
        for (int k = 0; k < 3; k++) begin wb(3, 0, 64'd0); cycle(); end
        idle();

        // Reset mid-stream with a held slot and cnt[5]=2
        issue(0, 0, 5, 1); cycle();
        issue(0, 0, 5, 1); cycle();
        idle(); out_ready = 0; cycle();
        reset = 0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("midrst_out_pc", out_pc, 64'd0);
        model_reset();
        @(negedge clk);
        reset = 1;
        idle();
        issue(5, 5, 0, 0); cycle();
        chk("post_rst_src1", out_src1, regs[5]);
        idle();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            if ($urandom_range(0, 3) != 0)
                issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                      1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) begin
                pick = $urandom_range(0, 31);
                for (int k = 0; k < 32; k++) begin
                    if (!wb_release && cnt[(pick + k) % 32] > 0)
                        wb((pick + k) % 32, 1'($urandom_range(0, 1)), {$urandom, $urandom});
                end
            end
            cycle();
        end

        // Drain remaining writers
        idle();
        for (int n = 0; n < 200; n++) begin
            idle();
            for (int k = 0; k < 32; k++) begin
                if (!wb_release && cnt[k] > 0) wb(k, 1, {$urandom, $urandom});
            end
            cycle();
        end
        idle();
        issue(7, 3, 0, 0); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
